// File: rtl/exception_arbiter.sv
// Trap sequencer for CP0: merges M-stage exceptions/ERET with synchronized hardware
// interrupts, emits a one-cycle commit pulse, then holds the pipeline flush.
module exception_arbiter #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  CAUSE_INT    = 5'd0,
  parameter logic [4:0]  CAUSE_ERET   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        excValid_M,
  input  logic [4:0]  excCause_M,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic        instrValid_M,
  input  logic        stall_M,
  input  logic [5:0]  hwInt,
  input  logic        sr_IE,
  input  logic        sr_EXL,
  input  logic [5:0]  sr_IM,
  output logic        isException,
  output logic [4:0]  exceptionCause,
  output logic [31:0] exceptionPC,
  output logic        flush,
  output logic [5:0]  intPending,
  output logic        busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAKE  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [5:0]       sync1Reg, sync2Reg;
  logic [4:0]       causeReg;
  logic [31:0]      pcReg;

  logic        mReady;
  logic        intReq;
  logic        excReq;
  logic        takeEvent;
  logic [4:0]  excCode;
  logic [31:0] epc;

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1Reg <= '0;
      sync2Reg <= '0;
    end else begin
      sync1Reg <= hwInt;
      sync2Reg <= sync1Reg;
    end
  end

  assign intPending = sync2Reg;

  // A stalled stage or a bubble must not commit anything, interrupts included.
  assign mReady    = instrValid_M & ~stall_M;
  assign intReq    = sr_IE & ~sr_EXL & (|(sync2Reg & sr_IM)) & mReady;
  assign excReq    = excValid_M & mReady;
  assign takeEvent = (stateReg == IDLE) & (intReq | excReq);
  assign excCode   = (excCause_M == CAUSE_ERET) ? CAUSE_ERET : excCause_M;
  assign epc       = bd_M ? (pc_M - 32'd4) : pc_M;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (intReq | excReq) begin
          stateNext = TAKE;
        end
      end
      TAKE: begin
        if (FLUSH_CYCLES > 0) begin
          stateNext = FLUSH;
          cntNext   = CNT_INIT;
        end else begin
          stateNext = IDLE;
        end
      end
      FLUSH: begin
        if (cntReg <= CNT_ONE) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cntReg - CNT_ONE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    isException = 1'b0;
    flush       = 1'b0;
    busy        = 1'b0;
    case (stateReg)
      TAKE: begin
        isException = 1'b1;
        flush       = 1'b1;
        busy        = 1'b1;
      end
      FLUSH: begin
        flush = 1'b1;
        busy  = 1'b1;
      end
      default: begin
        isException = 1'b0;
      end
    endcase
  end

  // Interrupt wins a same-cycle collision; the exception re-raises after return.
  always_ff @(posedge clk) begin
    if (!reset) begin
      causeReg <= '0;
      pcReg    <= '0;
    end else if (takeEvent) begin
      causeReg <= intReq ? CAUSE_INT : excCode;
      pcReg    <= epc;
    end
  end

  assign exceptionCause = causeReg;
  assign exceptionPC    = pcReg;

endmodule

// File: tb/tb_exception_arbiter.sv
// Bench for exception_arbiter: directed vector table plus random traffic against a
// flush-countdown reference model, for the default build and a FLUSH_CYCLES=0 build.
module tb_exception_arbiter;

  logic        clk;
  logic        reset;
  logic        excValid_M;
  logic [4:0]  excCause_M;
  logic [31:0] pc_M;
  logic        bd_M;
  logic        instrValid_M;
  logic        stall_M;
  logic [5:0]  hwInt;
  logic        sr_IE;
  logic        sr_EXL;
  logic [5:0]  sr_IM;

  logic        isException, isException0;
  logic [4:0]  exceptionCause, exceptionCause0;
  logic [31:0] exceptionPC, exceptionPC0;
  logic        flush, flush0;
  logic [5:0]  intPending, intPending0;
  logic        busy, busy0;

  int tests = 0;
  int failed = 0;

  exception_arbiter #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .excValid_M(excValid_M), .excCause_M(excCause_M),
    .pc_M(pc_M), .bd_M(bd_M), .instrValid_M(instrValid_M), .stall_M(stall_M),
    .hwInt(hwInt), .sr_IE(sr_IE), .sr_EXL(sr_EXL), .sr_IM(sr_IM),
    .isException(isException), .exceptionCause(exceptionCause),
    .exceptionPC(exceptionPC), .flush(flush), .intPending(intPending), .busy(busy)
  );

  exception_arbiter #(.FLUSH_CYCLES(0)) dutNoFlush (
    .clk(clk), .reset(reset), .excValid_M(excValid_M), .excCause_M(excCause_M),
    .pc_M(pc_M), .bd_M(bd_M), .instrValid_M(instrValid_M), .stall_M(stall_M),
    .hwInt(hwInt), .sr_IE(sr_IE), .sr_EXL(sr_EXL), .sr_IM(sr_IM),
    .isException(isException0), .exceptionCause(exceptionCause0),
    .exceptionPC(exceptionPC0), .flush(flush0), .intPending(intPending0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: remaining flush cycles per build, last committed event, hwInt history.
  int          fcM[2] = '{2, 0};
  int          remM[2];
  logic        pulseM[2];
  logic [4:0]  causeM[2];
  logic [31:0] pcM[2];
  logic [5:0]  hwHist[$] = '{6'd0, 6'd0};

  task automatic modelStep();
    logic [5:0] ip;
    logic       iReq, eReq;
    ip   = hwHist[0];
    iReq = sr_IE && !sr_EXL && ((ip & sr_IM) != 0) && instrValid_M && !stall_M;
    eReq = excValid_M && instrValid_M && !stall_M;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        remM[k] = 0; pulseM[k] = 0; causeM[k] = 0; pcM[k] = 0;
      end else if (remM[k] > 0) begin
        remM[k]--; pulseM[k] = 0;
      end else if (iReq || eReq) begin
        pulseM[k] = 1;
        remM[k]   = 1 + fcM[k];
        causeM[k] = iReq ? 5'd0 : excCause_M;
        pcM[k]    = bd_M ? pc_M - 32'd4 : pc_M;
      end else begin
        pulseM[k] = 0;
      end
    end
    if (!reset) begin
      hwHist = '{6'd0, 6'd0};
    end else begin
      hwHist.push_back(hwInt);
      void'(hwHist.pop_front());
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    check("m.isException", 32'(isException), 32'(pulseM[0]));
    check("m.cause", 32'(exceptionCause), 32'(causeM[0]));
    check("m.pc", exceptionPC, pcM[0]);
    check("m.flush", 32'(flush), 32'(remM[0] > 0));
    check("m.busy", 32'(busy), 32'(remM[0] > 0));
    check("m.intPending", 32'(intPending), 32'(hwHist[0]));
    check("m0.isException", 32'(isException0), 32'(pulseM[1]));
    check("m0.cause", 32'(exceptionCause0), 32'(causeM[1]));
    check("m0.pc", exceptionPC0, pcM[1]);
    check("m0.flush", 32'(flush0), 32'(remM[1] > 0));
    check("m0.busy", 32'(busy0), 32'(remM[1] > 0));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  typedef struct {
    logic        rst, ev;
    logic [4:0]  ec;
    logic [31:0] pc;
    logic        bd, iv, st;
    logic [5:0]  hw;
    logic        ie, exl;
    logic [5:0]  im;
    logic        xE;
    logic [4:0]  xC;
    logic [31:0] xPC;
    logic        xF;
    logic [5:0]  xI;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ev, logic [4:0] ec, logic [31:0] pc, logic bd,
                              logic iv, logic st, logic [5:0] hw, logic ie, logic exl,
                              logic [5:0] im, logic xE, logic [4:0] xC, logic [31:0] xPC,
                              logic xF, logic [5:0] xI);
    vec_t v;
    v.rst = rst; v.ev = ev; v.ec = ec; v.pc = pc; v.bd = bd; v.iv = iv; v.st = st;
    v.hw = hw; v.ie = ie; v.exl = exl; v.im = im;
    v.xE = xE; v.xC = xC; v.xPC = xPC; v.xF = xF; v.xI = xI;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    reset = 0; excValid_M = 0; excCause_M = 0; pc_M = 0; bd_M = 0; instrValid_M = 0;
    stall_M = 0; hwInt = 0; sr_IE = 0; sr_EXL = 0; sr_IM = 0;
    for (int k = 0; k < 2; k++) begin
      remM[k] = 0; pulseM[k] = 0; causeM[k] = 0; pcM[k] = 0;
    end

    //            rst ev ec     pc          bd iv st hw    ie exl im      xE xC     xPC         xF xI
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,    0, 0, 0, 6'h0, 0, 0, 6'h00, 0, 5'd0,  32'h0,    0, 6'h0)); // reset
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd0,  32'h0,    0, 6'h0));
    vecs.push_back(mk(1, 1, 5'd12, 32'h3000, 0, 1, 0, 6'h0, 0, 0, 6'h00, 1, 5'd12, 32'h3000, 1, 6'h0)); // exception
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 0, 6'h0));
    vecs.push_back(mk(1, 1, 5'd12, 32'h3004, 1, 1, 0, 6'h0, 0, 0, 6'h00, 1, 5'd12, 32'h3000, 1, 6'h0)); // delay slot
    vecs.push_back(mk(1, 1, 5'd4,  32'h3100, 0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 1, 6'h0)); // ignored
    vecs.push_back(mk(1, 1, 5'd4,  32'h3100, 0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 1, 6'h0));
    vecs.push_back(mk(1, 1, 5'd4,  32'h3100, 0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h3000, 0, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h4, 1, 1, 6'h3F, 0, 5'd12, 32'h3000, 0, 6'h0)); // int, EXL
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h4, 1, 1, 6'h3F, 0, 5'd12, 32'h3000, 0, 6'h4));
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h4, 1, 1, 6'h3F, 0, 5'd12, 32'h3000, 0, 6'h4));
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h4, 1, 0, 6'h3B, 0, 5'd12, 32'h3000, 0, 6'h4)); // IM[2]=0
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 1, 6'h4, 1, 0, 6'h3F, 0, 5'd12, 32'h3000, 0, 6'h4)); // stall
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h4, 1, 0, 6'h3F, 1, 5'd0,  32'h100,  1, 6'h4)); // taken
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h100,  1, 6'h4));
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h100,  1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h100,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h100,  0, 6'h0));
    vecs.push_back(mk(1, 1, 5'd31, 32'h200,  0, 1, 0, 6'h0, 1, 1, 6'h3F, 1, 5'd31, 32'h200,  1, 6'h0)); // ERET
    vecs.push_back(mk(1, 0, 5'd0,  32'h200,  0, 1, 0, 6'h0, 1, 1, 6'h3F, 0, 5'd31, 32'h200,  1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h200,  0, 1, 0, 6'h0, 1, 1, 6'h3F, 0, 5'd31, 32'h200,  1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h200,  0, 1, 0, 6'h0, 1, 1, 6'h3F, 0, 5'd31, 32'h200,  0, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h400,  0, 1, 0, 6'h4, 1, 0, 6'h3F, 0, 5'd31, 32'h200,  0, 6'h0)); // collision
    vecs.push_back(mk(1, 0, 5'd0,  32'h400,  0, 1, 0, 6'h4, 1, 0, 6'h3F, 0, 5'd31, 32'h200,  0, 6'h4));
    vecs.push_back(mk(1, 1, 5'd4,  32'h400,  0, 1, 0, 6'h4, 1, 0, 6'h3F, 1, 5'd0,  32'h400,  1, 6'h4));
    vecs.push_back(mk(1, 1, 5'd4,  32'h400,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h400,  1, 6'h4));
    vecs.push_back(mk(1, 1, 5'd4,  32'h400,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h400,  1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h400,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h400,  0, 6'h0));
    vecs.push_back(mk(1, 1, 5'd8,  32'h500,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 1, 5'd8,  32'h500,  1, 6'h0)); // reset mid-flush
    vecs.push_back(mk(1, 0, 5'd0,  32'h500,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd8,  32'h500,  1, 6'h0));
    vecs.push_back(mk(0, 0, 5'd0,  32'h500,  0, 1, 0, 6'h0, 1, 0, 6'h3F, 0, 5'd0,  32'h0,    0, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd0,  32'h0,    0, 6'h0));
    vecs.push_back(mk(1, 1, 5'd12, 32'h600,  0, 0, 0, 6'h0, 0, 0, 6'h00, 0, 5'd0,  32'h0,    0, 6'h0)); // bubble
    vecs.push_back(mk(1, 1, 5'd12, 32'h600,  0, 1, 0, 6'h0, 0, 0, 6'h00, 1, 5'd12, 32'h600,  1, 6'h0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h600,  0, 1, 0, 6'h0, 0, 0, 6'h00, 0, 5'd12, 32'h600,  1, 6'h0));

    #2;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; excValid_M = vecs[i].ev; excCause_M = vecs[i].ec; pc_M = vecs[i].pc;
      bd_M = vecs[i].bd; instrValid_M = vecs[i].iv; stall_M = vecs[i].st; hwInt = vecs[i].hw;
      sr_IE = vecs[i].ie; sr_EXL = vecs[i].exl; sr_IM = vecs[i].im;
      tick();
      check("v.isException", 32'(isException), 32'(vecs[i].xE));
      check("v.cause", 32'(exceptionCause), 32'(vecs[i].xC));
      check("v.pc", exceptionPC, vecs[i].xPC);
      check("v.flush", 32'(flush), 32'(vecs[i].xF));
      check("v.busy", 32'(busy), 32'(vecs[i].xF));
      check("v.intPending", 32'(intPending), 32'(vecs[i].xI));
      checkModel();
      $display("[TB] vec %0d: isException=%0b cause=%0d pc=%h flush=%0b intPending=%b | nf: isException=%0b flush=%0b",
               i, isException, exceptionCause, exceptionPC, flush, intPending, isException0, flush0);
    end

    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 49) != 0);
      excValid_M   = ($urandom_range(0, 4) == 0);
      excCause_M   = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(1, 30));
      pc_M         = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      bd_M         = 1'($urandom_range(0, 1));
      instrValid_M = ($urandom_range(0, 7) != 0);
      stall_M      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) hwInt = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      sr_IE        = ($urandom_range(0, 3) != 0);
      sr_EXL       = ($urandom_range(0, 3) == 0);
      sr_IM        = 6'($urandom_range(0, 63));
      tick();
      checkModel();
      if (isException)
        $display("[TB] rnd %0d: commit cause=%0d pc=%h", c, exceptionCause, exceptionPC);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
